// File: rtl/core_pkg.sv
// Shared TOY core types: register address, data word and writeback entry.
package core_pkg;

   localparam int unsigned NREGS = 16;

   typedef logic [3:0]  reg_addr_t;
   typedef logic [15:0] word_t;

   typedef struct packed {
      reg_addr_t addr;
      word_t     data;
   } wb_entry_t;

   function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t addr);
      return NREGS'(1) << addr;
   endfunction

endpackage

// File: rtl/core_wb_fifo.sv
// Two-push / one-pop circular queue of writeback entries with occupancy count.
// Entries and valids are exported in age order (index 0 = head, oldest).
module core_wb_fifo
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic                    clk_i,
   input  logic                    arst_ni,
   input  logic                    push_a_i,
   input  wb_entry_t               a_i,
   input  logic                    push_b_i,
   input  wb_entry_t               b_i,
   input  logic                    pop_i,
   output wb_entry_t               head_o,
   output logic [CW-1:0]           count_o,
   output wb_entry_t [DEPTH-1:0]   age_entries_o,
   output logic [DEPTH-1:0]        age_valid_o
);

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
      rd_ptr_d = rd_ptr_q + PW'(pop_i);
      count_d  = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // B lands behind A when both push; alone it takes the tail slot.
   always_ff @(posedge clk_i) begin
      if (push_a_i) mem_q[wr_ptr_q] <= a_i;
      if (push_b_i) mem_q[wr_ptr_q + PW'(push_a_i)] <= b_i;
   end

   always_comb begin
      age_entries_o = '0;
      age_valid_o   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         age_entries_o[k] = mem_q[rd_ptr_q + PW'(k)];
         age_valid_o[k]   = CW'(k) < count_q;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/core_arf_wb.sv
// Writeback collector for the architectural register file: queues MEM/EX results
// in program order and drains one write per cycle. Optional CORE_WB_BYPASS_EN lookup.
module core_arf_wb
   import core_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter bit          DROP_R0 = 1'b1,
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          arst_ni,
   input  logic          mem_valid_i,
   output logic          mem_ready_o,
   input  logic [3:0]    mem_addr_i,
   input  logic [15:0]   mem_data_i,
   input  logic          ex_valid_i,
   output logic          ex_ready_o,
   input  logic [3:0]    ex_addr_i,
   input  logic [15:0]   ex_data_i,
   output logic          wr_en_o,
   output logic [3:0]    wr_addr_o,
   output logic [15:0]   wr_data_o,
   output logic [15:0]   busy_o,
`ifdef CORE_WB_BYPASS_EN
   input  logic [3:0]    byp_addr_i,
   output logic          byp_hit_o,
   output logic [15:0]   byp_data_o,
`endif
   output logic [CW-1:0] count_o
);

   wb_entry_t             head;
   wb_entry_t             last_q;
   wb_entry_t [DEPTH-1:0] age_entries;
   logic [DEPTH-1:0]      age_valid;
   logic [CW-1:0]         count;
   logic [CW-1:0]         free;
   logic                  mem_hs, ex_hs, mem_push, ex_push, pop;

   // Free slots exclude the pop happening this same cycle.
   assign free        = CW'(DEPTH) - count;
   assign mem_ready_o = free != '0;
   assign ex_ready_o  = mem_valid_i ? (free >= CW'(2)) : (free != '0);

   assign mem_hs   = mem_valid_i & mem_ready_o;
   assign ex_hs    = ex_valid_i & ex_ready_o;
   assign mem_push = mem_hs & ~(DROP_R0 && (mem_addr_i == '0));
   assign ex_push  = ex_hs & ~(DROP_R0 && (ex_addr_i == '0));
   assign pop      = count != '0;

   core_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i         (clk_i),
      .arst_ni       (arst_ni),
      .push_a_i      (mem_push),
      .a_i           ('{addr: mem_addr_i, data: mem_data_i}),
      .push_b_i      (ex_push),
      .b_i           ('{addr: ex_addr_i, data: ex_data_i}),
      .pop_i         (pop),
      .head_o        (head),
      .count_o       (count),
      .age_entries_o (age_entries),
      .age_valid_o   (age_valid)
   );

   // Holds the last committed write so the write port stays quiet when empty.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         last_q <= '0;
      end else if (pop) begin
         last_q <= head;
      end
   end

   always_comb begin
      wr_en_o   = pop;
      wr_addr_o = pop ? head.addr : last_q.addr;
      wr_data_o = pop ? head.data : last_q.data;
   end

   always_comb begin
      busy_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k]) busy_o = busy_o | reg_onehot(age_entries[k].addr);
      end
   end

`ifdef CORE_WB_BYPASS_EN
   // Scan oldest to youngest so the youngest match overrides.
   always_comb begin
      byp_hit_o  = 1'b0;
      byp_data_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k] && (age_entries[k].addr == byp_addr_i)) begin
            byp_hit_o  = 1'b1;
            byp_data_o = age_entries[k].data;
         end
      end
   end
`endif

   assign count_o = count;

endmodule

// File: tb/tb_core_arf_wb.sv
// Scoreboard bench for core_arf_wb: queue model predicts readies/count/busy,
// a monitor checks each presented register write in handshake order.
`timescale 1ns/1ps
module tb_core_arf_wb;
   import core_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam bit          DROP_R0 = 1'b1;
   localparam int unsigned CW      = $clog2(DEPTH + 1);

   logic          clk_i = 1'b0;
   logic          arst_ni = 1'b0;
   logic          mem_valid_i = 1'b0;
   logic          mem_ready_o;
   logic [3:0]    mem_addr_i = '0;
   logic [15:0]   mem_data_i = '0;
   logic          ex_valid_i = 1'b0;
   logic          ex_ready_o;
   logic [3:0]    ex_addr_i = '0;
   logic [15:0]   ex_data_i = '0;
   logic          wr_en_o;
   logic [3:0]    wr_addr_o;
   logic [15:0]   wr_data_o;
   logic [15:0]   busy_o;
   logic [CW-1:0] count_o;
`ifdef CORE_WB_BYPASS_EN
   logic [3:0]    byp_addr_i = '0;
   logic          byp_hit_o;
   logic [15:0]   byp_data_o;
`endif

   core_arf_wb #(
      .DEPTH   (DEPTH),
      .DROP_R0 (DROP_R0)
   ) dut (
      .clk_i       (clk_i),
      .arst_ni     (arst_ni),
      .mem_valid_i (mem_valid_i),
      .mem_ready_o (mem_ready_o),
      .mem_addr_i  (mem_addr_i),
      .mem_data_i  (mem_data_i),
      .ex_valid_i  (ex_valid_i),
      .ex_ready_o  (ex_ready_o),
      .ex_addr_i   (ex_addr_i),
      .ex_data_i   (ex_data_i),
      .wr_en_o     (wr_en_o),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .busy_o      (busy_o),
`ifdef CORE_WB_BYPASS_EN
      .byp_addr_i  (byp_addr_i),
      .byp_hit_o   (byp_hit_o),
      .byp_data_o  (byp_data_o),
`endif
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   int        checks = 0;
   int        errors = 0;
   wb_entry_t ref_q[$];
   wb_entry_t sb_q[$];
   wb_entry_t last_e = '0;
   int        next_addr = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock edge: check readies just before it, update the model at it.
   task automatic tick();
      int d;
      int free;
      bit emr, eer, mh, eh;
      d = (4 - int'($time % 64'd10) + 10) % 10;
      if (d > 0) #(d);
      free = DEPTH - ref_q.size();
      emr  = free >= 1;
      eer  = free >= (mem_valid_i ? 2 : 1);
      chk("mem_ready", mem_ready_o, emr);
      chk("ex_ready", ex_ready_o, eer);
      mh = mem_valid_i && emr;
      eh = ex_valid_i && eer;
      if (ref_q.size() != 0) void'(ref_q.pop_front());
      if (mh && !(DROP_R0 && mem_addr_i == 4'd0)) begin
         ref_q.push_back('{addr: mem_addr_i, data: mem_data_i});
         sb_q.push_back('{addr: mem_addr_i, data: mem_data_i});
      end
      if (eh && !(DROP_R0 && ex_addr_i == 4'd0)) begin
         ref_q.push_back('{addr: ex_addr_i, data: ex_data_i});
         sb_q.push_back('{addr: ex_addr_i, data: ex_data_i});
      end
      @(negedge clk_i);
      if (mh) mem_valid_i = 1'b0;
      if (eh) ex_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_hs();
      int n;
      n = 0;
      while ((mem_valid_i || ex_valid_i) && n < 12) begin
         tick();
         n++;
      end
      chk("hs_timeout", {30'd0, mem_valid_i, ex_valid_i}, 32'd0);
   endtask

   task automatic req(input bit mv, input logic [3:0] ma, input logic [15:0] md,
                      input bit ev, input logic [3:0] ea, input logic [15:0] ed);
      mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md;
      ex_valid_i  = ev; ex_addr_i  = ea; ex_data_i  = ed;
      wait_hs();
   endtask

   // Monitor: every cycle compare state and the presented write against the scoreboard.
   initial begin
      logic [15:0] exp_busy;
      wb_entry_t   e;
      forever begin
         @(posedge clk_i);
         #1;
         if (arst_ni) begin
            chk("count", 32'(count_o), ref_q.size());
            exp_busy = '0;
            foreach (ref_q[i]) exp_busy[ref_q[i].addr] = 1'b1;
            chk("busy", 32'(busy_o), 32'(exp_busy));
            chk("wr_en", 32'(wr_en_o), 32'(ref_q.size() != 0));
            if (wr_en_o && sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
               chk("wr_data", 32'(wr_data_o), 32'(e.data));
               last_e = e;
            end else if (!wr_en_o) begin
               chk("hold_addr", 32'(wr_addr_o), 32'(last_e.addr));
               chk("hold_data", 32'(wr_data_o), 32'(last_e.data));
            end
         end
      end
   end

   initial begin
      #20;
      arst_ni = 1'b1;
      #1;
      chk("rst_wr_en", 32'(wr_en_o), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
      chk("rst_wr_data", 32'(wr_data_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_mem_ready", 32'(mem_ready_o), 32'd1);
      chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);

      // Single EX result, then same-address pair.
      req(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234);
      idle(3);
      req(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'hBBBB);
      idle(4);

      // Both producers streaming distinct addresses until back-pressure.
      for (int c = 0; c < 10; c++) begin
         if (!mem_valid_i) begin
            mem_valid_i = 1'b1; mem_addr_i = 4'(next_addr); mem_data_i = 16'(c * 16'h0101);
            next_addr = next_addr % 15 + 1;
         end
         if (!ex_valid_i) begin
            ex_valid_i = 1'b1; ex_addr_i = 4'(next_addr); ex_data_i = 16'(c * 16'h1010 + 1);
            next_addr = next_addr % 15 + 1;
         end
         tick();
      end
      wait_hs();
      idle(6);

      // R0 drops: EX alone, then MEM to R0 with EX live.
      req(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h5555);
      idle(2);
      req(1'b1, 4'd0, 16'h6666, 1'b1, 4'd9, 16'h7777);
      idle(3);

      // Fill three entries, then async reset between edges.
      req(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202);
      req(1'b1, 4'd4, 16'h0404, 1'b1, 4'd6, 16'h0606);
      #2;
      arst_ni = 1'b0;
      #1;
      chk("arst_wr_en", 32'(wr_en_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_count", 32'(count_o), 32'd0);
      ref_q.delete();
      sb_q.delete();
      last_e = '0;
      arst_ni = 1'b1;
      idle(2);

`ifdef CORE_WB_BYPASS_EN
      req(1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 16'h2222);
      byp_addr_i = 4'd7;
      #1;
      chk("byp_hit7", 32'(byp_hit_o), 32'd1);
      chk("byp_data7", 32'(byp_data_o), 32'h2222);
      byp_addr_i = 4'd8;
      #1;
      chk("byp_hit8", 32'(byp_hit_o), 32'd0);
      chk("byp_data8", 32'(byp_data_o), 32'h0);
      idle(4);
`endif

      // Randomized traffic with bursty and sparse phases.
      for (int c = 0; c < 400; c++) begin
         int p;
         p = (c / 50) % 2 ? 90 : 40;
         if (!mem_valid_i && $urandom_range(99, 0) < p) begin
            mem_valid_i = 1'b1; mem_addr_i = 4'($urandom_range(15, 0)); mem_data_i = 16'($urandom);
         end
         if (!ex_valid_i && $urandom_range(99, 0) < p) begin
            ex_valid_i = 1'b1; ex_addr_i = 4'($urandom_range(15, 0)); ex_data_i = 16'($urandom);
         end
         tick();
      end
      wait_hs();
      idle(DEPTH + 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
